// File: rtl/calc_sequencer_if.sv
// Command/handshake bundle between a requester and calc_sequencer.
// master: drives start/op/shamt and observes the register commands.
// slave:  the sequencer side.
interface calc_sequencer_if #(
  parameter int unsigned SHAMT_W = 2,
  parameter int unsigned CMD_W   = 4
);
  logic               start;
  logic [3:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [CMD_W-1:0]   Tx;
  logic [CMD_W-1:0]   Ty;
  logic [CMD_W-1:0]   Tz;
  logic [CMD_W-1:0]   Tula;
  logic               sel_b;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, op, shamt,
    input  Tx, Ty, Tz, Tula, sel_b, busy, done, err
  );

  modport slave (
    input  start, op, shamt,
    output Tx, Ty, Tz, Tula, sel_b, busy, done, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: runs one X/Y/Z + ULA operation per start/done handshake as a
// fixed sequence of register commands. All outputs are registered and decoded
// from the next state, so they change together with the state register.
// Optional feature macro: CALC_SHIFT_EN (SHL/SHR ops, SHIFT state, counter).
module calc_sequencer #(
  parameter int unsigned SHAMT_W = 2,
  parameter int unsigned CMD_W   = 4
) (
  input logic             clock,
  input logic             reset,
  calc_sequencer_if.slave bus
);

  localparam logic [2:0] CmdHold   = 3'd0;
  localparam logic [2:0] CmdLoad   = 3'd1;
  localparam logic [2:0] CmdShiftR = 3'd2;
  localparam logic [2:0] CmdShiftL = 3'd3;
  localparam logic [2:0] CmdReset  = 3'd4;

  localparam logic [3:0] OpAnd = 4'd6;
  localparam logic [3:0] OpShl = 4'd7;
  localparam logic [3:0] OpShr = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLda,
    StMovy,
    StLdb,
    StExec,
`ifdef CALC_SHIFT_EN
    StShift,
`endif
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             err_r_q, err_r_d;
  logic [CMD_W-1:0] tx_q, tx_d, ty_q, ty_d, tz_q, tz_d, tula_q, tula_d;
  logic             sel_b_q, sel_b_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

`ifdef CALC_SHIFT_EN
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_shamt;
  assign unused_shamt = ^bus.shamt;
`endif

  function automatic logic [CMD_W-1:0] cmd(input logic [2:0] c);
    return CMD_W'(c);
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
`ifdef CALC_SHIFT_EN
    return op <= OpShr;
`else
    return op <= OpAnd;
`endif
  endfunction

  // Next-state, latched-op, error-flag and shift-counter logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_r_d = err_r_q;
`ifdef CALC_SHIFT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d = bus.op;
`ifdef CALC_SHIFT_EN
          cnt_d = bus.shamt;
`endif
          if (op_legal(bus.op)) begin
            state_d = StClr;
            err_r_d = 1'b0;
          end else begin
            state_d = StDone;
            err_r_d = 1'b1;
          end
        end
      end
      StClr: state_d = StLda;
      StLda: state_d = StMovy;
      StMovy: begin
`ifdef CALC_SHIFT_EN
        if (op_q == OpShl || op_q == OpShr) begin
          state_d = (cnt_q == '0) ? StDone : StShift;
        end else begin
          state_d = StLdb;
        end
`else
        state_d = StLdb;
`endif
      end
      StLdb:  state_d = StExec;
      StExec: state_d = StDone;
`ifdef CALC_SHIFT_EN
      StShift: begin
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q <= SHAMT_W'(1)) state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
        err_r_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode of the state being entered; registered below.
  always_comb begin
    tx_d    = cmd(CmdHold);
    ty_d    = cmd(CmdHold);
    tz_d    = cmd(CmdHold);
    tula_d  = '0;
    sel_b_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_d)
      StIdle: busy_d = 1'b0;
      StClr: begin
        tx_d = cmd(CmdReset);
        ty_d = cmd(CmdReset);
        tz_d = cmd(CmdReset);
      end
      StLda:  tx_d = cmd(CmdLoad);
      StMovy: ty_d = cmd(CmdLoad);
      StLdb: begin
        tx_d    = cmd(CmdLoad);
        sel_b_d = 1'b1;
      end
      StExec: begin
        tula_d = CMD_W'(op_q[2:0]);
        tz_d   = cmd(CmdLoad);
      end
`ifdef CALC_SHIFT_EN
      StShift: ty_d = (op_q == OpShl) ? cmd(CmdShiftL) : cmd(CmdShiftR);
`endif
      StDone: begin
        done_d = 1'b1;
        err_d  = err_r_d;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // State and registered outputs; reset takes effect immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      err_r_q <= 1'b0;
      tx_q    <= cmd(CmdHold);
      ty_q    <= cmd(CmdHold);
      tz_q    <= cmd(CmdHold);
      tula_q  <= '0;
      sel_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CALC_SHIFT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_r_q <= err_r_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tz_q    <= tz_d;
      tula_q  <= tula_d;
      sel_b_q <= sel_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CALC_SHIFT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.Tx    = tx_q;
  assign bus.Ty    = ty_q;
  assign bus.Tz    = tz_q;
  assign bus.Tula  = tula_q;
  assign bus.sel_b = sel_b_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule
